// File: rtl/isa_pkg.sv
// isa_pkg: instruction field positions, opcode/cond encodings and flag indices for decode_issue.
package isa_pkg;
  localparam int F_COND   = 28;
  localparam int F_OP     = 24;
  localparam int F_S      = 23;
  localparam int F_RD     = 19;
  localparam int F_RN     = 15;
  localparam int F_RM     = 11;
  localparam int F_SRCONT = 8;
  localparam int F_SRBIT  = 3;
  localparam int F_IMM    = 0;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_ORR  = 4'b0011;
  localparam logic [3:0] OP_EOR  = 4'b0100;
  localparam logic [3:0] OP_MOV  = 4'b0101;
  localparam logic [3:0] OP_MOVI = 4'b0110;
  localparam logic [3:0] OP_SHF  = 4'b0111;
  localparam logic [3:0] OP_CMP  = 4'b1000;
  localparam logic [3:0] OP_LDR  = 4'b1101;
  localparam logic [3:0] OP_STR  = 4'b1110;

  localparam logic [3:0] C_EQ = 4'b0000;
  localparam logic [3:0] C_NE = 4'b0001;
  localparam logic [3:0] C_CS = 4'b0010;
  localparam logic [3:0] C_CC = 4'b0011;
  localparam logic [3:0] C_MI = 4'b0100;
  localparam logic [3:0] C_PL = 4'b0101;
  localparam logic [3:0] C_VS = 4'b0110;
  localparam logic [3:0] C_VC = 4'b0111;
  localparam logic [3:0] C_HI = 4'b1000;
  localparam logic [3:0] C_LS = 4'b1001;
  localparam logic [3:0] C_GE = 4'b1010;
  localparam logic [3:0] C_LT = 4'b1011;
  localparam logic [3:0] C_GT = 4'b1100;
  localparam logic [3:0] C_LE = 4'b1101;
  localparam logic [3:0] C_AL = 4'b1110;
  localparam logic [3:0] C_NV = 4'b1111;

  typedef struct packed {
    logic [3:0]  opcode;
    logic        s;
    logic [2:0]  sr_cont;
    logic [4:0]  sr_bit;
    logic [15:0] imm;
    logic [3:0]  rd;
    logic        rd_we;
  } ctrl_t;

  function automatic logic op_legal(input logic [3:0] op);
    return (op <= OP_CMP) || (op == OP_LDR) || (op == OP_STR);
  endfunction
endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: register file with two async read ports, one sync write port and write-to-read bypass.
module regfile_2r1w #(
  parameter int NREGS = 16,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [3:0]    waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [3:0]    raddr1_i,
  output logic [DW-1:0] rdata1_o,
  input  logic [3:0]    raddr2_i,
  output logic [DW-1:0] rdata2_o
);
  logic [DW-1:0] mem_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // a write landing this cycle is visible to the reader in the same cycle
  assign rdata1_o = (we_i && waddr_i == raddr1_i) ? wdata_i : mem_q[raddr1_i];
  assign rdata2_o = (we_i && waddr_i == raddr2_i) ? wdata_i : mem_q[raddr2_i];
endmodule

// File: rtl/decode_issue.sv
// decode_issue: decode/issue stage feeding the ALU with cond evaluation and register read.
// Optional DECODE_ISSUE_PERF_EN adds saturating squash_cnt/issue_cnt counters.
module decode_issue
  import isa_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_instr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    out_opcode,
  output logic          out_s,
  output logic [2:0]    out_sr_cont,
  output logic [4:0]    out_sr_bit,
  output logic [15:0]   out_imm,
  output logic [DW-1:0] out_in1,
  output logic [DW-1:0] out_in2,
  output logic [3:0]    out_rd,
  output logic          out_rd_we,
  input  logic          wb_en,
  input  logic [3:0]    wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          flags_we,
  input  logic [3:0]    flags_in,
  output logic [3:0]    flags,
  output logic          illegal_op
`ifdef DECODE_ISSUE_PERF_EN
  ,
  output logic [15:0]   squash_cnt,
  output logic [15:0]   issue_cnt
`endif
);
  logic          out_valid_q, out_valid_d;
  ctrl_t         ctrl_q, ctrl_d, ctrl_dec;
  logic [DW-1:0] in1_q, in1_d, in2_q, in2_d;
  logic [DW-1:0] rn_val, rm_val;
  logic [3:0]    flags_q, flags_d, flags_eff, op;
  logic          illegal_q, illegal_d;
  logic          accept, pass, legal, issue;

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, r;
    n  = f[FLAG_N];
    z  = f[FLAG_Z];
    cf = f[FLAG_C];
    v  = f[FLAG_V];
    case (c)
      C_EQ:    r = z;
      C_NE:    r = !z;
      C_CS:    r = cf;
      C_CC:    r = !cf;
      C_MI:    r = n;
      C_PL:    r = !n;
      C_VS:    r = v;
      C_VC:    r = !v;
      C_HI:    r = cf && !z;
      C_LS:    r = !cf || z;
      C_GE:    r = n == v;
      C_LT:    r = n != v;
      C_GT:    r = !z && (n == v);
      C_LE:    r = z || (n != v);
      C_AL:    r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  regfile_2r1w #(.NREGS(NREGS), .DW(DW)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (wb_en),
    .waddr_i  (wb_addr),
    .wdata_i  (wb_data),
    .raddr1_i (in_instr[F_RN +: 4]),
    .rdata1_o (rn_val),
    .raddr2_i (in_instr[F_RM +: 4]),
    .rdata2_o (rm_val)
  );

  assign op        = in_instr[F_OP +: 4];
  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  // an ALU flag update in the accept cycle is forwarded to the condition check
  assign flags_eff = flags_we ? flags_in : flags_q;
  assign pass      = cond_pass(in_instr[F_COND +: 4], flags_eff);
  assign legal     = op_legal(op);
  assign issue     = accept && pass && legal;

  always_comb begin
    ctrl_dec.opcode  = op;
    ctrl_dec.s       = in_instr[F_S] || (op == OP_CMP);
    ctrl_dec.sr_cont = in_instr[F_SRCONT +: 3];
    ctrl_dec.sr_bit  = in_instr[F_SRBIT +: 5];
    ctrl_dec.imm     = in_instr[F_IMM +: 16];
    ctrl_dec.rd      = in_instr[F_RD +: 4];
    ctrl_dec.rd_we   = !(op == OP_CMP || op == OP_STR);
    out_valid_d      = issue ? 1'b1 : (in_ready ? 1'b0 : out_valid_q);
    ctrl_d           = issue ? ctrl_dec : ctrl_q;
    in1_d            = issue ? rn_val : in1_q;
    in2_d            = issue ? rm_val : in2_q;
    flags_d          = flags_eff;
    illegal_d        = accept && pass && !legal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      flags_q     <= '0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      flags_q     <= flags_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_opcode  = ctrl_q.opcode;
  assign out_s       = ctrl_q.s;
  assign out_sr_cont = ctrl_q.sr_cont;
  assign out_sr_bit  = ctrl_q.sr_bit;
  assign out_imm     = ctrl_q.imm;
  assign out_rd      = ctrl_q.rd;
  assign out_rd_we   = ctrl_q.rd_we;
  assign out_in1     = in1_q;
  assign out_in2     = in2_q;
  assign flags       = flags_q;
  assign illegal_op  = illegal_q;

`ifdef DECODE_ISSUE_PERF_EN
  logic [15:0] squash_q, issue_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      squash_q <= '0;
      issue_q  <= '0;
    end else begin
      if (accept && !(pass && legal) && squash_q != 16'hFFFF) squash_q <= squash_q + 16'd1;
      if (out_valid_q && out_ready && issue_q != 16'hFFFF) issue_q <= issue_q + 16'd1;
    end
  end

  assign squash_cnt = squash_q;
  assign issue_cnt  = issue_q;
`endif
endmodule
